// File: rtl/data_reg_bank_reader.sv
// Readout sequencer for the 4-unit data register bank: snapshots the bank on start and
// streams one addressed word or all four words over a valid/ready handshake.
module data_reg_bank_reader #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             start,
  input  logic             readAll,
  input  logic [1:0]       address,
  input  logic             outReady,
  output logic [WIDTH-1:0] dataOut,
  output logic [1:0]       outAddress,
  output logic             outValid,
  output logic             outLast,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0][WIDTH-1:0]  snap_q, snap_d;
  logic [3:0][WIDTH-1:0]  in_words;
  logic [1:0]             idx_q, idx_d;
  logic [1:0]             last_idx_q, last_idx_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [1:0]             addr_q, addr_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [1:0]             start_idx;
  logic [1:0]             start_last;
  logic [1:0]             nxt_idx;

  function automatic logic [WIDTH-1:0] pick_word(input logic [3:0][WIDTH-1:0] words,
                                                 input logic [1:0] sel);
    return words[sel];
  endfunction

  assign in_words   = {in3, in2, in1, in0};
  assign start_idx  = readAll ? 2'd0 : address;
  assign start_last = readAll ? 2'd3 : address;
  assign nxt_idx    = idx_q + 2'd1;

  // Output registers are loaded one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    data_d     = data_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    last_d     = last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SEND;
          snap_d     = in_words;
          idx_d      = start_idx;
          last_idx_d = start_last;
          data_d     = pick_word(in_words, start_idx);
          addr_d     = start_idx;
          valid_d    = 1'b1;
          last_d     = (start_idx == start_last);
          busy_d     = 1'b1;
        end
      end
      SEND: begin
        if (outReady) begin
          if (last_q) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            data_d  = '0;
            addr_d  = 2'd0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = nxt_idx;
            data_d = pick_word(snap_q, nxt_idx);
            addr_d = nxt_idx;
            last_d = (nxt_idx == last_idx_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      idx_q      <= 2'd0;
      last_idx_q <= 2'd0;
      data_q     <= '0;
      addr_q     <= 2'd0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign dataOut    = data_q;
  assign outAddress = addr_q;
  assign outValid   = valid_q;
  assign outLast    = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_data_reg_bank_reader.sv
// Directed bench for data_reg_bank_reader: per-cycle vector table plus reset sequences.
module tb_data_reg_bank_reader;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in0, in1, in2, in3;
  logic             start;
  logic             readAll;
  logic [1:0]       address;
  logic             outReady;
  logic [WIDTH-1:0] dataOut;
  logic [1:0]       outAddress;
  logic             outValid;
  logic             outLast;
  logic             busy;
  logic             done;

  int checks;
  int errors;

  data_reg_bank_reader #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .start      (start),
    .readAll    (readAll),
    .address    (address),
    .outReady   (outReady),
    .dataOut    (dataOut),
    .outAddress (outAddress),
    .outValid   (outValid),
    .outLast    (outLast),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        ra;
    logic [1:0]  ad;
    logic [31:0] i0, i1, i2, i3;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  ea;
    logic        el;
    logic        eb;
    logic        edn;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic st, input logic ra, input logic [1:0] ad,
                              input logic [31:0] i0, input logic [31:0] i1,
                              input logic [31:0] i2, input logic [31:0] i3,
                              input logic rdy, input logic ev, input logic [31:0] ed,
                              input logic [1:0] ea, input logic el, input logic eb,
                              input logic edn);
    vec_t v;
    v.st = st; v.ra = ra; v.ad = ad;
    v.i0 = i0; v.i1 = i1; v.i2 = i2; v.i3 = i3;
    v.rdy = rdy; v.ev = ev; v.ed = ed; v.ea = ea; v.el = el; v.eb = eb; v.edn = edn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic ra, input logic [1:0] ad,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d, input logic rdy);
    start = st; readAll = ra; address = ad;
    in0 = a; in1 = b; in2 = c; in3 = d;
    outReady = rdy;
  endtask

  localparam logic [31:0] F = 32'hFFFF_FFFF;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 1'b0);

    // Asynchronous reset asserted between clock edges, bank inputs nonzero.
    #2;
    reset = 1'b1;
    #1;
    chk("rst_valid", {31'd0, outValid}, 32'd0);
    chk("rst_data", dataOut, 32'd0);
    chk("rst_addr", {30'd0, outAddress}, 32'd0);
    chk("rst_last", {31'd0, outLast}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    start = 1'b1;
    step();
    step();
    chk("rst_hold_valid", {31'd0, outValid}, 32'd0);
    chk("rst_hold_data", dataOut, 32'd0);
    #3;
    reset = 1'b0;
    start = 1'b0;
    step();
    chk("post_rst_valid", {31'd0, outValid}, 32'd0);

    // Per-cycle vectors: inputs before the edge, expected outputs after it.
    vecs[0]  = mk(1, 0, 2, 0, 0, 32'hDEADBEEF, 0, 1,  1, 32'hDEADBEEF, 2, 1, 1, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 1,  0, 0, 0, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 0, 1, 2, 3, 4, 1,             1, 1, 0, 0, 1, 0);
    vecs[4]  = mk(0, 0, 0, F, F, F, F, 1,             1, 2, 1, 0, 1, 0);
    vecs[5]  = mk(0, 0, 0, F, F, F, F, 1,             1, 3, 2, 0, 1, 0);
    vecs[6]  = mk(0, 0, 0, F, F, F, F, 1,             1, 4, 3, 1, 1, 0);
    vecs[7]  = mk(0, 0, 0, F, F, F, F, 1,             0, 0, 0, 0, 0, 1);
    vecs[8]  = mk(0, 0, 0, F, F, F, F, 0,             0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 1, 0, 32'h10, 32'h20, 32'h30, 32'h40, 1, 1, 32'h10, 0, 0, 1, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,             1, 32'h10, 0, 0, 1, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,             1, 32'h10, 0, 0, 1, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1,             1, 32'h20, 1, 0, 1, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,             1, 32'h20, 1, 0, 1, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 1,             1, 32'h30, 2, 0, 1, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 1,             1, 32'h40, 3, 1, 1, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1,             0, 0, 0, 0, 0, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    vecs[18] = mk(1, 1, 0, 5, 6, 7, 8, 1,             1, 5, 0, 0, 1, 0);
    vecs[19] = mk(1, 0, 1, 5, 6, 7, 8, 1,             1, 6, 1, 0, 1, 0);
    vecs[20] = mk(1, 0, 1, 5, 6, 7, 8, 1,             1, 7, 2, 0, 1, 0);
    vecs[21] = mk(0, 0, 0, 5, 6, 7, 8, 1,             1, 8, 3, 1, 1, 0);
    vecs[22] = mk(1, 0, 1, 0, 32'hAAAA, 0, 0, 1,      0, 0, 0, 0, 0, 1);
    vecs[23] = mk(1, 0, 1, 0, 32'hAAAA, 0, 0, 0,      1, 32'hAAAA, 1, 1, 1, 0);
    vecs[24] = mk(0, 0, 0, 0, 32'hAAAA, 0, 0, 0,      1, 32'hAAAA, 1, 1, 1, 0);
    vecs[25] = mk(0, 0, 0, 0, 32'hAAAA, 0, 0, 1,      0, 0, 0, 0, 0, 1);
    vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].st, vecs[i].ra, vecs[i].ad, vecs[i].i0, vecs[i].i1, vecs[i].i2,
            vecs[i].i3, vecs[i].rdy);
      step();
      chk($sformatf("v%0d_valid", i), {31'd0, outValid}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].eb});
      chk($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, vecs[i].edn});
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_data", i), dataOut, vecs[i].ed);
        chk($sformatf("v%0d_addr", i), {30'd0, outAddress}, {30'd0, vecs[i].ea});
        chk($sformatf("v%0d_last", i), {31'd0, outLast}, {31'd0, vecs[i].el});
      end
    end

    // Reset after the second transfer of an all-word burst.
    drive(1'b1, 1'b1, 2'd0, 32'h11, 32'h22, 32'h33, 32'h44, 1'b1);
    step();
    chk("mb_first", dataOut, 32'h11);
    start = 1'b0;
    step();
    step();
    chk("mb_third", dataOut, 32'h33);
    chk("mb_third_addr", {30'd0, outAddress}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("mb_rst_valid", {31'd0, outValid}, 32'd0);
    chk("mb_rst_busy", {31'd0, busy}, 32'd0);
    chk("mb_rst_data", dataOut, 32'd0);
    step();
    #3;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("mb_idle%0d_valid", k), {31'd0, outValid}, 32'd0);
      chk($sformatf("mb_idle%0d_done", k), {31'd0, done}, 32'd0);
    end
    drive(1'b1, 1'b1, 2'd0, 32'h55, 32'h66, 32'h77, 32'h88, 1'b0);
    step();
    start = 1'b0;
    chk("mb_new_valid", {31'd0, outValid}, 32'd1);
    chk("mb_new_data", dataOut, 32'h55);
    chk("mb_new_addr", {30'd0, outAddress}, 32'd0);
    chk("mb_new_last", {31'd0, outLast}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
